// File: rtl/pb_interrupt_controller.sv
// Picoblaze interrupt controller: rising-edge pending capture, per-source mask,
// single interrupt line with an ack/clear handshake and a port-mapped register file.
module pb_interrupt_controller #(
  parameter int unsigned NUM_SOURCES = 8,
  parameter logic [7:0]  PORT_STATUS = 8'h10,
  parameter logic [7:0]  PORT_MASK   = 8'h11,
  parameter logic [7:0]  PORT_CLEAR  = 8'h12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_src,
  output logic [NUM_SOURCES-1:0] irq_clear,
  input  logic [7:0]             port_id,
  input  logic                   write_strobe,
  input  logic                   read_strobe,
  input  logic [7:0]             out_port,
  output logic [7:0]             in_port,
  output logic                   interrupt,
  input  logic                   interrupt_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_SERVICE
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_SOURCES-1:0] src_q;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] mask_q, mask_d;
  logic [NUM_SOURCES-1:0] irq_clear_q;
  logic [NUM_SOURCES-1:0] rise;
  logic [NUM_SOURCES-1:0] clr_wr;
  logic [7:0]             in_port_q, in_port_d;
  logic                   interrupt_q, interrupt_d;
  logic                   clear_hit;
  logic                   mask_hit;
  logic                   req;

  // Reads have no side effects, so the read strobe is intentionally unused.
  logic unused_inputs;
  assign unused_inputs = read_strobe ^ (^out_port);

  always_comb begin
    clear_hit = write_strobe && (port_id == PORT_CLEAR);
    mask_hit  = write_strobe && (port_id == PORT_MASK);
    clr_wr    = clear_hit ? out_port[NUM_SOURCES-1:0] : '0;
    rise      = irq_src & ~src_q;
    // A rise wins over a simultaneous clear so no event is lost.
    pending_d = rise | (pending_q & ~clr_wr);
    mask_d    = mask_hit ? out_port[NUM_SOURCES-1:0] : mask_q;
    req       = |(pending_q & mask_q);

    in_port_d = '0;
    case (port_id)
      PORT_STATUS: in_port_d[NUM_SOURCES-1:0] = pending_q;
      PORT_MASK:   in_port_d[NUM_SOURCES-1:0] = mask_q;
      default:     in_port_d = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req)           state_d = S_ASSERT;
      S_ASSERT:  if (interrupt_ack) state_d = S_SERVICE;
      S_SERVICE: if (clear_hit)     state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
    interrupt_d = (state_d == S_ASSERT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      irq_clear_q <= '0;
      in_port_q   <= '0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= irq_src;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      irq_clear_q <= clr_wr;
      in_port_q   <= in_port_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign irq_clear = irq_clear_q;
  assign in_port   = in_port_q;
  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_pb_interrupt_controller.sv
// Bench for pb_interrupt_controller: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the controller.
module tb_pb_interrupt_controller;

  localparam logic [7:0] P_STATUS = 8'h10;
  localparam logic [7:0] P_MASK   = 8'h11;
  localparam logic [7:0] P_CLEAR  = 8'h12;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_src;
  logic [7:0] irq_clear;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state.
  bit [7:0] m_prev, m_pend, m_mask, m_clrp, m_rd;
  bit       m_waiting_ack, m_in_service;

  pb_interrupt_controller #(
    .NUM_SOURCES(8),
    .PORT_STATUS(P_STATUS),
    .PORT_MASK  (P_MASK),
    .PORT_CLEAR (P_CLEAR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_src      (irq_src),
    .irq_clear    (irq_clear),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit [7:0] clr;
    bit       wants;
    bit       clear_write;
    if (reset) begin
      m_prev = 0; m_pend = 0; m_mask = 0; m_clrp = 0; m_rd = 0;
      m_waiting_ack = 0; m_in_service = 0;
    end else begin
      clear_write = write_strobe && (port_id == P_CLEAR);
      clr   = clear_write ? out_port : 8'h00;
      wants = (m_pend & m_mask) != 8'h00;
      m_rd  = (port_id == P_STATUS) ? m_pend : (port_id == P_MASK) ? m_mask : 8'h00;
      if (!m_waiting_ack && !m_in_service && wants) m_waiting_ack = 1;
      else if (m_waiting_ack && interrupt_ack) begin
        m_waiting_ack = 0;
        m_in_service  = 1;
      end else if (m_in_service && clear_write) m_in_service = 0;
      m_pend = (irq_src & ~m_prev) | (m_pend & ~clr);
      if (write_strobe && port_id == P_MASK) m_mask = out_port;
      m_clrp = clr;
      m_prev = irq_src;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] data);
    port_id = port; out_port = data; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] port);
    port_id = port;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_src = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
    interrupt_ack = 1'b0; port_id = 8'h00; out_port = 8'h00;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_src = 8'hFF; write_strobe = 1'b0; read_strobe = 1'b0;
    interrupt_ack = 1'b0; port_id = P_STATUS; out_port = 8'h00;
    tick(); tick();
    n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL t1_int: got %b want 0", interrupt); end
    n_cmp++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL t1_inport: got %h want 00", in_port); end
    n_cmp++; if (irq_clear !== 8'h00) begin n_fail++; $display("FAIL t1_clr: got %h want 00", irq_clear); end
    reset = 1'b0;
    rd(P_MASK);
    n_cmp++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL t1_mask: got %h want 00", in_port); end
    rd(P_STATUS);
    n_cmp++; if (in_port !== 8'hFF) begin n_fail++; $display("FAIL t1_status: got %h want ff", in_port); end
    n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL t1_int_masked: got %b want 0", interrupt); end
    irq_src = 8'h00;
  endtask

  task automatic test_basic();
    do_reset();
    wr(P_MASK, 8'h01);
    irq_src = 8'h01;
    tick();
    n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL t2_int_early: got %b want 0", interrupt); end
    irq_src = 8'h00;
    tick();
    n_cmp++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL t2_int_on: got %b want 1", interrupt); end
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL t2_int_ack: got %b want 0", interrupt); end
    rd(P_STATUS);
    n_cmp++; if (in_port !== 8'h01) begin n_fail++; $display("FAIL t2_status: got %h want 01", in_port); end
    wr(P_CLEAR, 8'h01);
    n_cmp++; if (irq_clear !== 8'h01) begin n_fail++; $display("FAIL t2_clr_pulse: got %h want 01", irq_clear); end
    rd(P_STATUS);
    n_cmp++; if (irq_clear !== 8'h00) begin n_fail++; $display("FAIL t2_clr_end: got %h want 00", irq_clear); end
    rd(P_STATUS);
    n_cmp++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL t2_status_clr: got %h want 00", in_port); end
    n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL t2_idle: got %b want 0", interrupt); end
  endtask

  task automatic test_masked();
    bit seen = 0;
    do_reset();
    irq_src = 8'h08;
    tick();
    rd(P_STATUS);
    rd(P_STATUS);
    n_cmp++; if (in_port !== 8'h08) begin n_fail++; $display("FAIL t3_status: got %h want 08", in_port); end
    n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL t3_masked: got %b want 0", interrupt); end
    wr(P_MASK, 8'h08);
    for (int k = 0; k < 2 && !seen; k++) begin
      if (interrupt === 1'b1) seen = 1;
      else tick();
    end
    if (interrupt === 1'b1) seen = 1;
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL t3_unmask: got %b want 1 within 2 cycles", interrupt); end
    irq_src = 8'h00;
  endtask

  task automatic test_collision();
    do_reset();
    wr(P_MASK, 8'h04);
    irq_src = 8'h04;
    tick(); tick();
    n_cmp++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL t4_int: got %b want 1", interrupt); end
    interrupt_ack = 1'b1; irq_src = 8'h00;
    tick();
    interrupt_ack = 1'b0;
    irq_src = 8'h04;
    wr(P_CLEAR, 8'h04);
    n_cmp++; if (irq_clear !== 8'h04) begin n_fail++; $display("FAIL t4_clr_pulse: got %h want 04", irq_clear); end
    n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL t4_int_idle: got %b want 0", interrupt); end
    rd(P_STATUS);
    n_cmp++; if (in_port !== 8'h04) begin n_fail++; $display("FAIL t4_status: got %h want 04", in_port); end
    n_cmp++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL t4_reassert: got %b want 1", interrupt); end
    irq_src = 8'h00;
  endtask

  task automatic test_hold();
    do_reset();
    wr(P_MASK, 8'hFF);
    irq_src = 8'h01;
    tick(); tick();
    irq_src = 8'h00;
    wr(P_MASK, 8'h00);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL t5_hold[%0d]: got %b want 1", k, interrupt); end
      tick();
    end
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL t5_ack: got %b want 0", interrupt); end
    wr(P_CLEAR, 8'hFF);
    interrupt_ack = 1'b1;
    tick(); tick();
    interrupt_ack = 1'b0;
    n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL t5_spurious: got %b want 0", interrupt); end
    wr(P_MASK, 8'h02);
    irq_src = 8'h02;
    tick(); tick();
    n_cmp++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL t5_after_spurious: got %b want 1", interrupt); end
    irq_src = 8'h00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(P_MASK, 8'h01);
    irq_src = 8'h01;
    tick(); tick();
    n_cmp++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL t6_pre: got %b want 1", interrupt); end
    irq_src = 8'h00; reset = 1'b1;
    port_id = P_CLEAR; out_port = 8'h01; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0; reset = 1'b0;
    n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL t6_int: got %b want 0", interrupt); end
    n_cmp++; if (irq_clear !== 8'h00) begin n_fail++; $display("FAIL t6_clr: got %h want 00", irq_clear); end
    rd(P_STATUS);
    n_cmp++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL t6_status: got %h want 00", in_port); end
    n_cmp++; if (irq_clear !== 8'h00) begin n_fail++; $display("FAIL t6_clr2: got %h want 00", irq_clear); end
  endtask

  task automatic test_random();
    logic [7:0] ports [5];
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ports[0] = P_STATUS; ports[1] = P_MASK; ports[2] = P_CLEAR;
      ports[3] = 8'h13;    ports[4] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) irq_src = 8'($urandom);
      port_id       = ports[$urandom_range(0, 4)];
      write_strobe  = ($urandom_range(0, 99) < 30);
      read_strobe   = ($urandom_range(0, 3) == 0);
      out_port      = 8'($urandom);
      interrupt_ack = ($urandom_range(0, 5) == 0);
      reset         = ($urandom_range(0, 599) == 0);
      tick();
      n_cmp++; if (interrupt !== m_waiting_ack) begin n_fail++; $display("FAIL rnd_int[%0d]: got %b want %b", c, interrupt, m_waiting_ack); end
      n_cmp++; if (in_port !== m_rd) begin n_fail++; $display("FAIL rnd_inport[%0d]: got %h want %h", c, in_port, m_rd); end
      n_cmp++; if (irq_clear !== m_clrp) begin n_fail++; $display("FAIL rnd_clr[%0d]: got %h want %h", c, irq_clear, m_clrp); end
    end
    reset = 1'b0; write_strobe = 1'b0; interrupt_ack = 1'b0; read_strobe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masked();
    test_collision();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
